// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_multi
// Description : Multi-channel runtime-programmable clock divider and tick
//               strobe generator. Each channel divides clk by its active
//               divisor D (>= 2) and produces a registered divided clock
//               (floor(D/2) cycles high, ceil(D/2) low) plus a one-cycle
//               tick coincident with each rising edge of that clock.
//               Divisor writes land in a per-channel shadow register and are
//               applied at the next period boundary (wrap, enable start or
//               sync), so the output never glitches.
// Ports       : clk        system clock
//               i_rst      synchronous active-high reset
//               i_en       per-channel enable
//               i_sync     one-cycle pulse, restarts enabled channels in phase
//               i_wr       divisor write strobe
//               i_wr_ch    target channel of the write
//               i_wr_div   divisor value written (clamped to >= 2)
//               o_clk      divided clock per channel
//               o_tick     one-cycle strobe per channel
//               o_pending  shadow divisor written but not yet active
// Revision    : 1.0 - initial multi-channel release
// ============================================================================
module clk_div_multi #(
  parameter  int NCH     = 4,
  parameter  int DIV_W   = 16,
  parameter  int DEF_DIV = 1042,
  localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic [NCH-1:0]   i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CH_W-1:0]  i_wr_ch,
  input  logic [DIV_W-1:0] i_wr_div,
  output logic [NCH-1:0]   o_clk,
  output logic [NCH-1:0]   o_tick,
  output logic [NCH-1:0]   o_pending
);

  localparam logic [DIV_W-1:0] c_min_div = DIV_W'(2);
  localparam logic [DIV_W-1:0] c_def_div = (DEF_DIV < 2) ? c_min_div : DIV_W'(DEF_DIV);
  localparam logic [CH_W:0]    c_nch     = (CH_W + 1)'(NCH);

  logic             w_wr_ok;
  logic [DIV_W-1:0] w_wr_div_c;

  // The write channel field may encode values beyond NCH-1; those are dropped.
  assign w_wr_ok    = i_wr && ({1'b0, i_wr_ch} < c_nch);
  assign w_wr_div_c = (i_wr_div < c_min_div) ? c_min_div : i_wr_div;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DIV_W-1:0] r_act;
    logic [DIV_W-1:0] r_shd;
    logic [DIV_W-1:0] r_cnt;
    logic             r_clk;
    logic             r_tick;
    logic             r_pend;
    logic             r_en_q;
    logic             w_sel;
    logic             w_start;
    logic             w_wrap;
    logic             w_bound;

    assign w_sel   = w_wr_ok && (i_wr_ch == CH_W'(c));
    assign w_start = i_en[c] && !r_en_q;
    // D >= 2 always, so D-1 never underflows; cnt never exceeds D-1 because
    // the active divisor only changes when cnt is (re)set to zero.
    assign w_wrap  = (r_cnt == (r_act - DIV_W'(1)));
    assign w_bound = w_start || i_sync || w_wrap;

    always_ff @(posedge clk) begin
      if (i_rst) begin
        r_act  <= c_def_div;
        r_shd  <= c_def_div;
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
        r_pend <= 1'b0;
        r_en_q <= 1'b0;
      end else begin
        r_en_q <= i_en[c];

        if (!i_en[c]) begin
          r_cnt  <= '0;
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
        end else if (w_bound) begin
          r_cnt  <= '0;
          r_clk  <= 1'b1;
          r_tick <= 1'b1;
          if (r_pend) begin
            r_act  <= r_shd;
            r_pend <= 1'b0;
          end
        end else begin
          r_cnt  <= r_cnt + DIV_W'(1);
          r_tick <= 1'b0;
          r_clk  <= ((r_cnt + DIV_W'(1)) < (r_act >> 1));
        end

        // Placed after the boundary logic so a coincident write wins the
        // pending flag while the boundary consumes the previous shadow value.
        if (w_sel) begin
          r_shd <= w_wr_div_c;
          if (i_en[c]) begin
            r_pend <= 1'b1;
          end else begin
            r_act  <= w_wr_div_c;
            r_pend <= 1'b0;
          end
        end
      end
    end

    assign o_clk[c]     = r_clk;
    assign o_tick[c]    = r_tick;
    assign o_pending[c] = r_pend;
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_multi
// Description : Self-checking bench for clk_div_multi. A cycle-level model
//               tracks each channel as (position within period, divisor,
//               shadow, pending) and derives the expected outputs from the
//               period rules; it is compared against the DUT every cycle.
//               A vector table and directed sequences cover the corner cases,
//               followed by a randomized run.
// Revision    : 1.0 - initial bench
// ============================================================================
module tb_clk_div_multi;

  localparam int NCH   = 5;
  localparam int DIV_W = 16;
  localparam int DEFD  = 1042;
  localparam int CH_W  = 3;

  logic             clk = 1'b0;
  logic             i_rst = 1'b1;
  logic [NCH-1:0]   i_en = '0;
  logic             i_sync = 1'b0;
  logic             i_wr = 1'b0;
  logic [CH_W-1:0]  i_wr_ch = '0;
  logic [DIV_W-1:0] i_wr_div = '0;
  logic [NCH-1:0]   o_clk;
  logic [NCH-1:0]   o_tick;
  logic [NCH-1:0]   o_pending;

  clk_div_multi #(.NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(DEFD)) dut (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_en      (i_en),
    .i_sync    (i_sync),
    .i_wr      (i_wr),
    .i_wr_ch   (i_wr_ch),
    .i_wr_div  (i_wr_div),
    .o_clk     (o_clk),
    .o_tick    (o_tick),
    .o_pending (o_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state per channel.
  int m_phase [NCH];
  int m_d     [NCH];
  int m_shd   [NCH];
  bit m_pend  [NCH];
  bit m_enp   [NCH];
  bit m_clk   [NCH];
  bit m_tick  [NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      if (i_rst) begin
        m_phase[c] = 0; m_d[c] = DEFD; m_shd[c] = DEFD;
        m_pend[c] = 0; m_enp[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
      end else begin
        if (!i_en[c]) begin
          m_phase[c] = 0;
        end else if (!m_enp[c] || i_sync || m_phase[c] == m_d[c] - 1) begin
          if (m_pend[c]) begin
            m_d[c] = m_shd[c];
            m_pend[c] = 0;
          end
          m_phase[c] = 0;
        end else begin
          m_phase[c]++;
        end
        m_tick[c] = i_en[c] && (m_phase[c] == 0);
        m_clk[c]  = i_en[c] && (m_phase[c] < m_d[c] / 2);
        m_enp[c]  = i_en[c];
        if (i_wr && int'(i_wr_ch) == c) begin
          m_shd[c] = (int'(i_wr_div) < 2) ? 2 : int'(i_wr_div);
          if (i_en[c]) m_pend[c] = 1;
          else begin
            m_d[c] = m_shd[c];
            m_pend[c] = 0;
          end
        end
      end
    end
  endtask

  task automatic step();
    logic [NCH-1:0] ec, et, ep;
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < NCH; c++) begin
      ec[c] = m_clk[c]; et[c] = m_tick[c]; ep[c] = m_pend[c];
    end
    check("model_clk", 32'(o_clk), 32'(ec));
    check("model_tick", 32'(o_tick), 32'(et));
    check("model_pending", 32'(o_pending), 32'(ep));
  endtask

  task automatic do_wr(input int ch, input int div);
    i_wr = 1'b1; i_wr_ch = CH_W'(ch); i_wr_div = DIV_W'(div);
    step();
    i_wr = 1'b0;
  endtask

  typedef struct {
    logic             rst;
    logic [NCH-1:0]   en;
    logic             sync;
    logic             wr;
    logic [CH_W-1:0]  ch;
    logic [DIV_W-1:0] div;
    logic [NCH-1:0]   e_clk;
    logic [NCH-1:0]   e_tick;
    logic [NCH-1:0]   e_pend;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, tk, guard, cnt;
    int ticks [$];

    // Channel 2: clamped writes while disabled, then D=2 toggling, then a
    // write coincident with a wrap that stays pending one period.
    tbl[0]  = '{1'b1, 5'b00000, 1'b0, 1'b0, 3'd0, 16'd0, 5'b00000, 5'b00000, 5'b00000};
    tbl[1]  = '{1'b0, 5'b00000, 1'b0, 1'b1, 3'd2, 16'd0, 5'b00000, 5'b00000, 5'b00000};
    tbl[2]  = '{1'b0, 5'b00000, 1'b0, 1'b1, 3'd2, 16'd1, 5'b00000, 5'b00000, 5'b00000};
    tbl[3]  = '{1'b0, 5'b00100, 1'b0, 1'b0, 3'd0, 16'd0, 5'b00100, 5'b00100, 5'b00000};
    tbl[4]  = '{1'b0, 5'b00100, 1'b0, 1'b0, 3'd0, 16'd0, 5'b00000, 5'b00000, 5'b00000};
    tbl[5]  = '{1'b0, 5'b00100, 1'b0, 1'b0, 3'd0, 16'd0, 5'b00100, 5'b00100, 5'b00000};
    tbl[6]  = '{1'b0, 5'b00100, 1'b0, 1'b0, 3'd0, 16'd0, 5'b00000, 5'b00000, 5'b00000};
    tbl[7]  = '{1'b0, 5'b00100, 1'b0, 1'b1, 3'd2, 16'd3, 5'b00100, 5'b00100, 5'b00100};
    tbl[8]  = '{1'b0, 5'b00100, 1'b0, 1'b0, 3'd0, 16'd0, 5'b00000, 5'b00000, 5'b00100};
    tbl[9]  = '{1'b0, 5'b00100, 1'b0, 1'b0, 3'd0, 16'd0, 5'b00100, 5'b00100, 5'b00000};
    tbl[10] = '{1'b0, 5'b00100, 1'b0, 1'b0, 3'd0, 16'd0, 5'b00000, 5'b00000, 5'b00000};
    tbl[11] = '{1'b0, 5'b00100, 1'b0, 1'b0, 3'd0, 16'd0, 5'b00000, 5'b00000, 5'b00000};
    tbl[12] = '{1'b0, 5'b00100, 1'b0, 1'b0, 3'd0, 16'd0, 5'b00100, 5'b00100, 5'b00000};
    tbl[13] = '{1'b0, 5'b00000, 1'b0, 1'b0, 3'd0, 16'd0, 5'b00000, 5'b00000, 5'b00000};

    for (int i = 0; i < 14; i++) begin
      i_rst = tbl[i].rst; i_en = tbl[i].en; i_sync = tbl[i].sync;
      i_wr = tbl[i].wr; i_wr_ch = tbl[i].ch; i_wr_div = tbl[i].div;
      step();
      check($sformatf("tbl%0d_clk", i), 32'(o_clk), 32'(tbl[i].e_clk));
      check($sformatf("tbl%0d_tick", i), 32'(o_tick), 32'(tbl[i].e_tick));
      check($sformatf("tbl%0d_pend", i), 32'(o_pending), 32'(tbl[i].e_pend));
    end
    i_wr = 1'b0;

    // Default divisor on channel 0 after reset.
    i_rst = 1'b1; step(); i_rst = 1'b0;
    i_en = 5'b00001; step();
    check("t1_first_tick", 32'(o_tick[0]), 32'd1);
    check("t1_others_idle", 32'(o_clk[4:1]), 32'd0);
    hi = 0; tk = 0;
    for (int i = 0; i < 2 * DEFD; i++) begin
      hi += int'(o_clk[0]); tk += int'(o_tick[0]);
      step();
    end
    check("t1_ticks", 32'(tk), 32'd2);
    check("t1_high_cycles", 32'(hi), 32'(DEFD));

    // Channel 1: D=3, write 5 mid-period.
    i_en = '0; step();
    do_wr(1, 3);
    i_en = 5'b00010; step(); step();
    do_wr(1, 5);
    check("t2_pending_set", 32'(o_pending[1]), 32'd1);
    step();
    check("t2_wrap_tick", 32'(o_tick[1]), 32'd1);
    check("t2_pending_clr", 32'(o_pending[1]), 32'd0);
    repeat (12) step();

    // Four channels with distinct divisors, then a sync pulse.
    i_en = '0; step();
    do_wr(0, 4); do_wr(1, 6); do_wr(2, 7); do_wr(3, 10);
    i_en = 5'b01111;
    repeat (13) step();
    i_sync = 1'b1; step(); i_sync = 1'b0;
    check("t4_sync_ticks", 32'(o_tick[3:0]), 32'hf);
    repeat (70) step();

    // Write 8 to channel 0 on its wrap edge with D=4.
    i_en = '0; step();
    do_wr(0, 4);
    i_en = 5'b00001; step();
    guard = 0;
    while (m_phase[0] != m_d[0] - 1 && guard < 20) begin
      step(); guard++;
    end
    check("t5_find_wrap", 32'(guard < 20), 32'd1);
    do_wr(0, 8);
    check("t5_wrap_tick", 32'(o_tick[0]), 32'd1);
    for (int i = 1; i < 14; i++) begin
      step();
      if (o_tick[0]) ticks.push_back(i);
    end
    check("t5_tick_count", 32'(ticks.size() >= 2), 32'd1);
    if (ticks.size() >= 2) begin
      check("t5_period_a", 32'(ticks[0]), 32'd4);
      check("t5_period_b", 32'(ticks[1] - ticks[0]), 32'd8);
    end

    // Disable channel 3 in its high phase with an out-of-range write.
    i_en = 5'b01111;
    repeat (20) step();
    guard = 0;
    while (m_phase[3] != 2 && guard < 30) begin
      step(); guard++;
    end
    check("t6_find_high", 32'(o_clk[3]), 32'd1);
    i_en = 5'b00111;
    i_wr = 1'b1; i_wr_ch = 3'd5; i_wr_div = 16'd3;
    step();
    i_wr = 1'b0;
    check("t6_dis_clk", 32'(o_clk[3]), 32'd0);
    check("t6_oor_pending", 32'(o_pending), 32'd0);
    repeat (3) step();
    i_rst = 1'b1; step();
    check("t6_rst_clk", 32'(o_clk), 32'd0);
    check("t6_rst_tick", 32'(o_tick), 32'd0);
    i_rst = 1'b0; i_en = 5'b00001; step();
    check("t6_restart_tick", 32'(o_tick[0]), 32'd1);
    cnt = 0;
    do begin
      step(); cnt++;
    end while (!o_tick[0] && cnt < 1100);
    check("t6_default_period", 32'(cnt), 32'(DEFD));

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) i_en[$urandom_range(0, NCH - 1)] ^= 1'b1;
      i_sync = ($urandom_range(0, 39) == 0);
      i_wr   = ($urandom_range(0, 9) == 0);
      i_wr_ch  = CH_W'($urandom_range(0, 7));
      i_wr_div = DIV_W'($urandom_range(0, 12));
      i_rst  = ($urandom_range(0, 599) == 0);
      step();
    end
    i_rst = 1'b0; i_wr = 1'b0; i_sync = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
